// File: rtl/irq_ctrl_pkg.sv
// Shared constants, register map and helpers for the irq_ctrl interrupt aggregator.
package irq_ctrl_pkg;

    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned NUM_IRQ = 4;
    localparam int unsigned ROUTE_W = 2;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ID_W    = 16;

    typedef enum logic [1:0] {
        REG_MASK  = 2'd0,
        REG_ROUTE = 2'd1,
        REG_CLEAR = 2'd2,
        REG_SET   = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [MAX_SRC-1:0] mask;
        logic [MAX_SRC-1:0] pending;
    } status_t;

    // Two-bit IRQ line selected for source idx.
    function automatic logic [ROUTE_W-1:0] route_of(input logic [DATA_W-1:0] route,
                                                    input int unsigned idx);
        return route[idx*ROUTE_W +: ROUTE_W];
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// NMPSM3 port-bus view of irq_ctrl: write strobe, id, data out and the status word.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic              write;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] status;

    modport master (output write, output id, output din, input status);
    modport slave  (input write, input id, input din, output status);

endinterface

// File: rtl/irq_edge_det.sv
// One-bit rising-edge detector with an optional 2-flop synchronizer in front.
// Define IRQC_SYNC_EN to insert the synchronizer for asynchronous sources.
module irq_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    output logic edge_c
);

    logic s;
    logic s_q;

`ifdef IRQC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], src_i};
        end
    end

    assign s = sync_q[1];
`else
    assign s = src_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= s;
        end
    end

    assign edge_c = s & ~s_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: edge-latches up to 8 sources, masks and routes them onto IRQ0..3.
// Build option IRQC_SYNC_EN adds a 2-flop synchronizer per source (see irq_edge_det).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [ID_W-1:0] BASE_ID = 16'h00A0,
    parameter int unsigned     NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    irq_ctrl_if.slave          bus,
    input  logic [MAX_SRC-1:0] src,
    input  logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_IRQ-1:0] irq
);

    // Bits at or above NUM_SRC never hold state.
    localparam logic [MAX_SRC-1:0] SRC_MASK = MAX_SRC'((64'd1 << NUM_SRC) - 64'd1);

    logic [MAX_SRC-1:0] mask_q,    mask_d;
    logic [DATA_W-1:0]  route_q,   route_d;
    logic [MAX_SRC-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_q,     irq_d;

    logic [MAX_SRC-1:0] src_edge_c;
    logic [ID_W-1:0]    id_off_c;
    logic               reg_hit_c;
    reg_sel_e           reg_sel_c;
    logic               wr_mask_c, wr_route_c, wr_clear_c, wr_set_c;
    logic [MAX_SRC-1:0] ack_clr_c, set_terms_c, clr_terms_c;
    status_t            status_c;

    for (genvar g = 0; g < MAX_SRC; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            irq_edge_det u_edge (
                .clk    (clk),
                .reset  (reset),
                .src_i  (src[g]),
                .edge_c (src_edge_c[g])
            );
        end else begin : g_tied
            assign src_edge_c[g] = 1'b0;
        end
    end

    // Register decode: a write hits when id falls in BASE_ID..BASE_ID+3.
    always_comb begin
        id_off_c   = bus.id - BASE_ID;
        reg_hit_c  = bus.write && (id_off_c < ID_W'(4));
        reg_sel_c  = reg_sel_e'(id_off_c[1:0]);
        wr_mask_c  = reg_hit_c && (reg_sel_c == REG_MASK);
        wr_route_c = reg_hit_c && (reg_sel_c == REG_ROUTE);
        wr_clear_c = reg_hit_c && (reg_sel_c == REG_CLEAR);
        wr_set_c   = reg_hit_c && (reg_sel_c == REG_SET);
    end

    // Next-state for configuration, pending and irq; set beats clear.
    always_comb begin
        mask_d      = mask_q;
        route_d     = route_q;
        ack_clr_c   = '0;
        irq_d       = '0;

        if (wr_mask_c) begin
            mask_d = bus.din[MAX_SRC-1:0] & SRC_MASK;
        end
        if (wr_route_c) begin
            route_d = bus.din;
        end

        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            ack_clr_c[i] = irq_ack[route_of(route_q, i)];
        end

        set_terms_c = src_edge_c | (wr_set_c ? bus.din[MAX_SRC-1:0] : '0);
        clr_terms_c = ack_clr_c | (wr_clear_c ? bus.din[MAX_SRC-1:0] : '0);
        pending_d   = (set_terms_c | (pending_q & ~clr_terms_c)) & SRC_MASK;

        for (int unsigned n = 0; n < NUM_IRQ; n++) begin
            for (int unsigned i = 0; i < MAX_SRC; i++) begin
                if (pending_q[i] && mask_q[i] && (route_of(route_q, i) == ROUTE_W'(n))) begin
                    irq_d[n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            route_q   <= '0;
            pending_q <= '0;
            irq_q     <= '0;
        end else begin
            mask_q    <= mask_d;
            route_q   <= route_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        status_c.mask    = mask_q;
        status_c.pending = pending_q;
    end

    assign bus.status = status_c;
    assign irq        = irq_q;

endmodule
